// File: rtl/regdst_pipe_mux.sv
// regdst_pipe_mux: register-destination selector feeding a valid-tagged delay line.
// Picks one of N_IN channels or one of two constant addresses, loads the choice
// into stage 0 on a load strobe, and shifts it STAGES deep so the address lines up
// with write-back. Flush kills every in-flight entry. Illegal selector codes set a
// sticky error flag.
module regdst_pipe_mux #(
    parameter int WIDTH   = 5,
    parameter int N_IN    = 3,
    parameter int SEL_W   = 3,
    parameter int CONST_A = 29,
    parameter int CONST_B = 31,
    parameter int STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    load,
    input  logic                    err_clr,
    input  logic [SEL_W-1:0]        selector,
    input  logic [N_IN*WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    out_valid,
    output logic                    sel_err
);

    logic [WIDTH-1:0]  sel_val;
    logic              sel_ill;

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic              sel_err_q;
    logic              sel_err_d;

    // Selection mux: channels first, then the two constants, anything else falls back to channel 0.
    always_comb begin
        sel_val = data_in[0 +: WIDTH];
        sel_ill = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (selector == SEL_W'(i)) begin
                sel_val = data_in[i*WIDTH +: WIDTH];
            end
        end
        if (selector == SEL_W'(N_IN)) begin
            sel_val = WIDTH'(CONST_A);
        end else if (selector == SEL_W'(N_IN + 1)) begin
            sel_val = WIDTH'(CONST_B);
        end else if (int'(selector) > N_IN + 1) begin
            sel_ill = 1'b1;
        end
    end

    // Next state of the delay line and the sticky error; data keeps moving under flush.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end
        valid_d    = '0;
        data_d[0]  = load ? sel_val : data_q[0];
        valid_d[0] = load & ~flush;
        for (int k = 1; k < STAGES; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1] & ~flush;
        end
        // Set beats clear when both happen on the same edge.
        sel_err_d = (load & sel_ill & ~flush) | (sel_err_q & ~err_clr);
    end

    // State registers with synchronous reset that overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
            valid_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign data_out  = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign sel_err   = sel_err_q;

endmodule
